// File: rtl/spi_shifter_pkg.sv
// Shared definitions for the SPI serial data path: FSM state encoding,
// default frame width and the SCLK edge-flag selection helper.
package spi_shifter_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_XFER   = 2'd2
    } state_t;

    // The baud generator provides two flag sets; which one is meaningful
    // depends on whether the first SCLK transition is a send or a sample.
    function automatic logic sel_edge(input logic cpol,
                                      input logic cpha,
                                      input logic flag_odd,
                                      input logic flag_even);
        return (cpol ^ cpha) ? flag_odd : flag_even;
    endfunction

endpackage

// File: rtl/spi_shifter_if.sv
// Bus bundle between the APB register block / baud generator (master side)
// and the SPI shifter (slave side).
// Optional feature macro: SPI_SHIFTER_LOOPBACK_EN adds loopback_i.
interface spi_shifter_if
    import spi_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
    logic                  ss_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  lsbfe_i;
    logic                  send_data_i;
    logic [DATA_WIDTH-1:0] data_mosi_i;
    logic                  mosi_send_sclk_i;
    logic                  mosi_send_sclk0_i;
    logic                  miso_receive_sclk_i;
    logic                  miso_receive_sclk0_i;
    logic                  miso_i;
`ifdef SPI_SHIFTER_LOOPBACK_EN
    logic                  loopback_i;
`endif
    logic                  mosi_o;
    logic [DATA_WIDTH-1:0] data_miso_o;
    logic                  busy_o;
    logic                  rx_done_o;

    modport master (
        output ss_i, cpol_i, cpha_i, lsbfe_i, send_data_i, data_mosi_i,
        output mosi_send_sclk_i, mosi_send_sclk0_i,
        output miso_receive_sclk_i, miso_receive_sclk0_i, miso_i,
`ifdef SPI_SHIFTER_LOOPBACK_EN
        output loopback_i,
`endif
        input  mosi_o, data_miso_o, busy_o, rx_done_o
    );

    modport slave (
        input  ss_i, cpol_i, cpha_i, lsbfe_i, send_data_i, data_mosi_i,
        input  mosi_send_sclk_i, mosi_send_sclk0_i,
        input  miso_receive_sclk_i, miso_receive_sclk0_i, miso_i,
`ifdef SPI_SHIFTER_LOOPBACK_EN
        input  loopback_i,
`endif
        output mosi_o, data_miso_o, busy_o, rx_done_o
    );

endinterface

// File: rtl/spi_shifter_bit_counter.sv
// Saturating bit counter with synchronous clear; tc flags that MAX was reached.
module spi_shifter_bit_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);
    assign tc = (cnt == CW'(MAX));

    // Count enabled events, holding at MAX; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_shifter.sv
// SPI master serial data path: shifts a parallel TX word out on mosi_o on
// send-edge flags and assembles the RX word from receive-edge flags.
// Optional feature macro: SPI_SHIFTER_LOOPBACK_EN (RX samples mosi_o when
// loopback_i=1).
module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input logic          PCLK,
    input logic          PRESET,
    spi_shifter_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state_q, state_d;
    logic                  load, abort, done, cnt_clr;
    logic                  tx_edge, rx_edge, tx_fire, rx_fire;
    logic [CW-1:0]         tx_cnt, rx_cnt, tx_idx, rx_idx;
    logic                  tx_tc, rx_tc;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, rx_mask, tx_aligned;
    logic                  tx_bit, rx_sample;
    logic                  mosi_q, rx_done_q;
    logic [DATA_WIDTH-1:0] data_miso_q;

    assign tx_edge = sel_edge(bus.cpol_i, bus.cpha_i,
                              bus.mosi_send_sclk_i, bus.mosi_send_sclk0_i);
    assign rx_edge = sel_edge(bus.cpol_i, bus.cpha_i,
                              bus.miso_receive_sclk_i, bus.miso_receive_sclk0_i);

    // TX may start in LOADED so the first bit is on the line before the first sample edge.
    assign tx_fire = (state_q != ST_IDLE) && !bus.ss_i && tx_edge && !tx_tc;
    assign rx_fire = (state_q == ST_XFER) && !bus.ss_i && rx_edge && !rx_tc;

    // Bit position for the current count in the selected bit order.
    assign tx_idx = bus.lsbfe_i ? tx_cnt : CW'(DATA_WIDTH - 1) - tx_cnt;
    assign rx_idx = bus.lsbfe_i ? rx_cnt : CW'(DATA_WIDTH - 1) - rx_cnt;

    assign tx_aligned = tx_shift >> tx_idx;
    assign tx_bit     = tx_aligned[0];

`ifdef SPI_SHIFTER_LOOPBACK_EN
    assign rx_sample = bus.loopback_i ? mosi_q : bus.miso_i;
`else
    assign rx_sample = bus.miso_i;
`endif

    // RX word with the sampled bit merged in; also the completed word on the last edge.
    assign rx_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << rx_idx;
    assign rx_next = rx_sample ? (rx_shift | rx_mask) : (rx_shift & ~rx_mask);

    assign cnt_clr = load | abort | done;

    spi_shifter_bit_counter #(.MAX(DATA_WIDTH), .CW(CW)) u_tx_cnt (
        .clk (PCLK),
        .rst (PRESET),
        .clr (cnt_clr),
        .en  (tx_fire),
        .cnt (tx_cnt),
        .tc  (tx_tc)
    );

    spi_shifter_bit_counter #(.MAX(DATA_WIDTH), .CW(CW)) u_rx_cnt (
        .clk (PCLK),
        .rst (PRESET),
        .clr (cnt_clr),
        .en  (rx_fire),
        .cnt (rx_cnt),
        .tc  (rx_tc)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: loads only from IDLE, abort has priority over completion.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.send_data_i) begin
                    state_d = ST_LOADED;
                    load    = 1'b1;
                end
            end
            ST_LOADED: begin
                if (!bus.ss_i) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (bus.ss_i) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (rx_fire && (rx_cnt == CW'(DATA_WIDTH - 1))) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data path: TX latch, serial output, RX assembly and completed-word register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            mosi_q      <= 1'b0;
            data_miso_q <= '0;
            rx_done_q   <= 1'b0;
        end else begin
            rx_done_q <= done;
            if (load) begin
                tx_shift <= bus.data_mosi_i;
                rx_shift <= '0;
            end
            if (tx_fire) begin
                mosi_q <= tx_bit;
            end
            if (rx_fire) begin
                rx_shift <= rx_next;
            end
            if (done) begin
                data_miso_q <= rx_next;
            end
        end
    end

    assign bus.mosi_o      = mosi_q;
    assign bus.data_miso_o = data_miso_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.rx_done_o   = rx_done_q;

endmodule
